// File: rtl/ci_if_hs_multi.sv
// Multi-channel req/ack crossing: four-phase handshake (ACK_EN=1) or toggle mode; o_sen 3, o_rdy 6 cycles after i_req (SYNC=2).
// No backpressure: a request arriving while its channel is busy is dropped, flagged on o_drop and counted.
module ci_if_hs_multi #(
   parameter int CH     = 4,
   parameter int SYNC   = 2,
   parameter int ACK_EN = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_ena_m,
   input  logic          i_ena_s,
   input  logic [CH-1:0] i_req,
   input  logic          i_drop_clr,
   output logic [CH-1:0] o_sen,
   output logic [CH-1:0] o_rdy,
   output logic [CH-1:0] o_busy,
   output logic [CH-1:0] o_drop,
   output logic [7:0]    o_drop_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK} st_t;

   st_t             state     [CH];
   st_t             state_nxt [CH];
   logic [SYNC-1:0] s_q       [CH];
   logic [SYNC-1:0] a_q       [CH];
   logic [CH-1:0]   r_m;
   logic [CH-1:0]   r_m_nxt;
   logic [CH-1:0]   rdy_nxt;
   logic [CH-1:0]   sen_nxt;
   logic [CH-1:0]   drop_now;
   logic [4:0]      drop_pop;
   logic [8:0]      cnt_sum;
   logic [7:0]      cnt_nxt;

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < CH; i++) begin
         if (!i_rst_n) begin
            state[i] <= ST_IDLE;
         end else begin
            state[i] <= state_nxt[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         state_nxt[i] = state[i];
         if (ACK_EN != 0 && i_ena_m) begin
            case (state[i])
               ST_IDLE: if (i_req[i])           state_nxt[i] = ST_REQ;
               ST_REQ:  if (a_q[i][SYNC-1])     state_nxt[i] = ST_ACK;
               ST_ACK:  if (!a_q[i][SYNC-1])    state_nxt[i] = ST_IDLE;
               default:                         state_nxt[i] = ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      r_m_nxt  = r_m;
      rdy_nxt  = '0;
      drop_now = '0;
      sen_nxt  = '0;
      o_busy   = '0;
      for (int i = 0; i < CH; i++) begin
         if (ACK_EN != 0) begin
            if (i_ena_m) begin
               if (state[i] == ST_IDLE && i_req[i]) r_m_nxt[i] = 1'b1;
               if (state[i] == ST_REQ && a_q[i][SYNC-1]) begin
                  r_m_nxt[i] = 1'b0;
                  rdy_nxt[i] = 1'b1;
               end
               drop_now[i] = i_req[i] && (state[i] != ST_IDLE);
            end
            o_busy[i]  = (state[i] != ST_IDLE);
            sen_nxt[i] = i_ena_s && s_q[i][SYNC-2] && !s_q[i][SYNC-1];
         end else begin
            if (i_ena_m && i_req[i]) r_m_nxt[i] = ~r_m[i];
            // Toggle mode: every level change seen at the slave is one event
            sen_nxt[i] = i_ena_s && (s_q[i][SYNC-2] ^ s_q[i][SYNC-1]);
         end
      end
   end

   always_comb begin
      drop_pop = '0;
      for (int i = 0; i < CH; i++) begin
         drop_pop = drop_pop + 5'(drop_now[i]);
      end
      cnt_sum = {1'b0, o_drop_cnt} + {4'b0, drop_pop};
      // Clear discards history only; this cycle's drops still count
      if (i_drop_clr) begin
         cnt_nxt = {3'b0, drop_pop};
      end else if (cnt_sum[8]) begin
         cnt_nxt = 8'hFF;
      end else begin
         cnt_nxt = cnt_sum[7:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_m        <= '0;
         o_sen      <= '0;
         o_rdy      <= '0;
         o_drop     <= '0;
         o_drop_cnt <= '0;
         for (int i = 0; i < CH; i++) begin
            s_q[i] <= '0;
            a_q[i] <= '0;
         end
      end else begin
         r_m        <= r_m_nxt;
         o_sen      <= sen_nxt;
         o_rdy      <= rdy_nxt;
         o_drop     <= drop_now;
         o_drop_cnt <= cnt_nxt;
         for (int i = 0; i < CH; i++) begin
            if (i_ena_s) s_q[i] <= {s_q[i][SYNC-2:0], r_m[i]};
            if (i_ena_m && ACK_EN != 0) a_q[i] <= {a_q[i][SYNC-2:0], s_q[i][SYNC-1]};
         end
      end
   end

endmodule
